// File: rtl/vic_init_sequencer.sv
// Bring-up master: fills video RAM with {FILL_HI, addr[7:0]}, then copies a register image into the VIC.
// Latency: strobe starts the clock after start is seen in IDLE; FILL_LEN*HOLD_CYCLES + NUM_REGS*(1+HOLD_CYCLES) clocks total.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy. Optional IRQ ack via `VIC_IRQ_ACK_EN.
module vic_init_sequencer #(
    parameter int          NUM_REGS    = 47,
    parameter int          FILL_LEN    = 1000,
    parameter logic [3:0]  FILL_HI     = 4'h1,
    parameter int          HOLD_CYCLES = 8,
    parameter int          RAM_AW      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_AW-1:0] ram_di,
    output logic              ram_we,
    output logic [5:0]        tab_addr,
    input  logic [7:0]        tab_data,
    output logic [5:0]        vic_ain,
    output logic [7:0]        vic_di,
    output logic              vic_cs,
    output logic              vic_we,
    input  logic              irq
);

`ifdef VIC_IRQ_ACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_FETCH, S_WRITE, S_DONE, S_IRQWAIT, S_IRQACK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_FETCH, S_WRITE, S_DONE
    } state_t;
`endif

    // Terminal counts; counters stop on these compares and never rely on wrap.
    localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [RAM_AW-1:0] FILL_LAST = RAM_AW'(FILL_LEN - 1);
    localparam logic [5:0]        IDX_LAST  = 6'(NUM_REGS - 1);

    state_t              state, state_nxt;
    logic [7:0]          hold_cnt, hold_cnt_nxt;
    logic [RAM_AW-1:0]   addr_cnt, addr_cnt_nxt;
    logic [5:0]          idx, idx_nxt;

    logic                busy_nxt, done_nxt, ram_we_nxt, vic_cs_nxt;
    logic [RAM_AW-1:0]   ram_addr_nxt, ram_di_nxt;
    logic [5:0]          tab_addr_nxt, vic_ain_nxt;
    logic [7:0]          vic_di_nxt;

    // Fill word: colour nibble above the low address byte, zero-padded to the RAM width.
    function automatic logic [RAM_AW-1:0] fill_word(input logic [RAM_AW-1:0] a);
        logic [RAM_AW+11:0] w;
        w = {{RAM_AW{1'b0}}, FILL_HI, a[7:0]};
        return w[RAM_AW-1:0];
    endfunction

`ifndef VIC_IRQ_ACK_EN
    logic unused_irq;
    assign unused_irq = irq;
`endif

    // Next state, counters and next output values; outputs hold unless a state changes them.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        addr_cnt_nxt = addr_cnt;
        idx_nxt      = idx;
        ram_addr_nxt = ram_addr;
        ram_di_nxt   = ram_di;
        ram_we_nxt   = 1'b0;
        tab_addr_nxt = tab_addr;
        vic_ain_nxt  = vic_ain;
        vic_di_nxt   = vic_di;
        vic_cs_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                // Table address parks at 0 so the synchronous ROM already presents entry 0.
                tab_addr_nxt = '0;
                if (start) begin
                    hold_cnt_nxt = '0;
                    addr_cnt_nxt = '0;
                    idx_nxt      = '0;
                    if (FILL_LEN == 0) begin
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt    = S_FILL;
                        ram_we_nxt   = 1'b1;
                        ram_addr_nxt = '0;
                        ram_di_nxt   = fill_word('0);
                    end
                end
            end

            S_FILL: begin
                ram_we_nxt = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    hold_cnt_nxt = '0;
                    if (addr_cnt == FILL_LAST) begin
                        ram_we_nxt = 1'b0;
                        state_nxt  = S_FETCH;
                    end else begin
                        // Back-to-back words: the address steps on the hold boundary.
                        addr_cnt_nxt = addr_cnt + RAM_AW'(1);
                        ram_addr_nxt = addr_cnt + RAM_AW'(1);
                        ram_di_nxt   = fill_word(addr_cnt + RAM_AW'(1));
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            S_FETCH: begin
                // tab_addr has shown idx since the previous write, so tab_data is valid now.
                state_nxt    = S_WRITE;
                vic_cs_nxt   = 1'b1;
                vic_ain_nxt  = idx;
                vic_di_nxt   = tab_data;
                hold_cnt_nxt = '0;
                // Prefetch the next entry during this write; hold the last index at the end.
                tab_addr_nxt = (idx == IDX_LAST) ? idx : idx + 6'd1;
            end

            S_WRITE: begin
                vic_cs_nxt = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    vic_cs_nxt   = 1'b0;
                    hold_cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
`ifdef VIC_IRQ_ACK_EN
                        state_nxt = S_IRQWAIT;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        idx_nxt   = idx + 6'd1;
                        state_nxt = S_FETCH;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

`ifdef VIC_IRQ_ACK_EN
            S_IRQWAIT: begin
                if (irq) begin
                    state_nxt    = S_IRQACK;
                    vic_cs_nxt   = 1'b1;
                    vic_ain_nxt  = 6'h19;
                    vic_di_nxt   = 8'h01;
                    hold_cnt_nxt = '0;
                end
            end

            S_IRQACK: begin
                vic_cs_nxt = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    vic_cs_nxt   = 1'b0;
                    hold_cnt_nxt = '0;
                    state_nxt    = S_DONE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
`endif

            S_DONE: begin
                if (start) begin
                    state_nxt    = S_IDLE;
                    tab_addr_nxt = '0;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end

    // State, counters and registered outputs; reset drops every strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            hold_cnt <= '0;
            addr_cnt <= '0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_addr <= '0;
            ram_di   <= '0;
            ram_we   <= 1'b0;
            tab_addr <= '0;
            vic_ain  <= '0;
            vic_di   <= '0;
            vic_cs   <= 1'b0;
            vic_we   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            addr_cnt <= addr_cnt_nxt;
            idx      <= idx_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            ram_addr <= ram_addr_nxt;
            ram_di   <= ram_di_nxt;
            ram_we   <= ram_we_nxt;
            tab_addr <= tab_addr_nxt;
            vic_ain  <= vic_ain_nxt;
            vic_di   <= vic_di_nxt;
            vic_cs   <= vic_cs_nxt;
            vic_we   <= vic_cs_nxt;
        end
    end

endmodule

// File: tb/tb_vic_init_sequencer.sv
// Directed bench for vic_init_sequencer: one instance with a short fill, one with no fill and 64 registers.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each instance reads a synchronous ROM model whose data follows tab_addr by one clock.
module tb_vic_init_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_z = 1'b0;
    logic        irq = 1'b0;

    logic        busy, done, ram_we, vic_cs, vic_we;
    logic [11:0] ram_addr, ram_di;
    logic [5:0]  tab_addr, vic_ain;
    logic [7:0]  tab_data, vic_di;

    logic        busy_z, done_z, ram_we_z, vic_cs_z, vic_we_z;
    logic [11:0] ram_addr_z, ram_di_z;
    logic [5:0]  tab_addr_z, vic_ain_z;
    logic [7:0]  tab_data_z, vic_di_z;

    logic [7:0]  rom [64];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) tab_data   <= rom[tab_addr];
    always @(posedge clk) tab_data_z <= rom[tab_addr_z];

    vic_init_sequencer #(
        .NUM_REGS(47), .FILL_LEN(4), .FILL_HI(4'h1), .HOLD_CYCLES(8), .RAM_AW(12)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we),
        .tab_addr(tab_addr), .tab_data(tab_data),
        .vic_ain(vic_ain), .vic_di(vic_di), .vic_cs(vic_cs), .vic_we(vic_we),
        .irq(irq)
    );

    vic_init_sequencer #(
        .NUM_REGS(64), .FILL_LEN(0), .FILL_HI(4'h1), .HOLD_CYCLES(8), .RAM_AW(12)
    ) dut_z (
        .clk(clk), .reset(reset), .start(start_z), .busy(busy_z), .done(done_z),
        .ram_addr(ram_addr_z), .ram_di(ram_di_z), .ram_we(ram_we_z),
        .tab_addr(tab_addr_z), .tab_data(tab_data_z),
        .vic_ain(vic_ain_z), .vic_di(vic_di_z), .vic_cs(vic_cs_z), .vic_we(vic_we_z),
        .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, assertions %0d failures %0d", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen, writes, extra, cs_we_diff;
        logic prev_cs;
        logic [5:0] last_ain;

        for (int i = 0; i < 64; i++) rom[i] = 8'(8'h40 + 3 * i);
        rom[0]  = 8'h20;
        rom[17] = 8'h98;
        rom[24] = 8'h04;

        // 1. Reset held 3 clocks with start pulses that must be ignored.
        reset = 1'b1; start = 1'b1; start_z = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_busy", busy, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_done", done, 0);
        end
        reset = 1'b0; start = 1'b0; start_z = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_ram_addr", ram_addr, 0);
        check("idle_ram_di", ram_di, 0);
        check("idle_ram_we", ram_we, 0);
        check("idle_tab_addr", tab_addr, 0);
        check("idle_vic_ain", vic_ain, 0);
        check("idle_vic_di", vic_di, 0);
        check("idle_vic_cs", vic_cs, 0);
        check("idle_vic_we", vic_we, 0);
        check("idle_busy_z", busy_z, 0);

        // 2. Fill of 4 words, 8 clocks each, back to back.
        start = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tick();
            start = 1'b0;
            check("fill_we", ram_we, 1);
            check("fill_addr", ram_addr, 32'(c / 8));
            check("fill_di", ram_di, 32'(12'h100 + c / 8));
            check("fill_busy", busy, 1);
        end
        tick();
        check("fill_end_we", ram_we, 0);
        check("fetch0_cs", vic_cs, 0);
        check("fetch0_busy", busy, 1);

        // 3. 47 register writes in index order, 8 clocks each with one idle clock between.
        for (int r = 0; r < 47; r++) begin
            for (int h = 0; h < 8; h++) begin
                tick();
                check("wr_cs", vic_cs, 1);
                check("wr_we", vic_we, 1);
                if (h == 0) begin
                    check("wr_ain", vic_ain, 32'(r));
                    check("wr_di", vic_di, 32'(rom[r]));
                    if (r == 0)  check("wr_reg00", vic_di, 32'h20);
                    if (r == 17) check("wr_reg11", vic_di, 32'h98);
                    if (r == 24) check("wr_reg18", vic_di, 32'h04);
                end
            end
            tick();
            check("gap_cs", vic_cs, 0);
            check("gap_we", vic_we, 0);
        end

`ifdef VIC_IRQ_ACK_EN
        // 6. Wait for the interrupt, then acknowledge it.
        check("irqwait_busy", busy, 1);
        check("irqwait_done", done, 0);
        repeat (100) tick();
        check("irqwait_busy_late", busy, 1);
        check("irqwait_cs", vic_cs, 0);
        check("irqwait_done_late", done, 0);
        irq = 1'b1;
        for (int h = 0; h < 8; h++) begin
            tick();
            irq = 1'b0;
            check("ack_cs", vic_cs, 1);
            check("ack_we", vic_we, 1);
            check("ack_ain", vic_ain, 32'h19);
            check("ack_di", vic_di, 32'h01);
        end
        tick();
        check("ack_done", done, 1);
        check("ack_busy", busy, 0);
        check("ack_cs_end", vic_cs, 0);
`else
        check("done_after_last", done, 1);
        check("busy_after_last", busy, 0);
`endif

        // Re-arm from DONE: one clock in IDLE, then the fill restarts.
        start = 1'b1;
        tick();
        check("rearm_done", done, 0);
        check("rearm_busy", busy, 0);
        tick();
        check("rearm_we", ram_we, 1);
        check("rearm_addr", ram_addr, 0);
        check("rearm_busy2", busy, 1);
        repeat (7) tick();
        check("start_ignored_addr", ram_addr, 0);
        tick();
        check("word1_addr", ram_addr, 1);
        start = 1'b0;
        repeat (8) tick();
        check("word2_addr", ram_addr, 2);
        check("word2_we", ram_we, 1);

        // 4. Reset at word 2, with start raised at the same moment.
        reset = 1'b1; start = 1'b1;
        #1;
        check("async_rst_we", ram_we, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_addr", ram_addr, 0);
        tick();
        check("rst_start_busy", busy, 0);
        check("rst_start_we", ram_we, 0);
        reset = 1'b0;
        tick();
        start = 1'b0;
        check("restart_we", ram_we, 1);
        check("restart_addr", ram_addr, 0);
        check("restart_di", ram_di, 32'h100);
        check("restart_busy", busy, 1);
`ifdef VIC_IRQ_ACK_EN
        irq = 1'b1;
`endif
        for (int k = 0; k < 2000 && !done; k++) tick();
        irq = 1'b0;
        check("rerun_done", done, 1);
        check("rerun_tab_addr", tab_addr, 46);

        // 5. No fill, 64 registers: last index 6'h3f, no wrap.
        start_z = 1'b1;
        tick();
        start_z = 1'b0;
        check("z_busy", busy_z, 1);
        check("z_we", ram_we_z, 0);
        we_seen = 0; writes = 0; cs_we_diff = 0; prev_cs = 1'b0; last_ain = '0;
        for (int k = 0; k < 64 * 9; k++) begin
            tick();
            if (ram_we_z) we_seen++;
            if (vic_cs_z && !prev_cs) writes++;
            if (vic_cs_z) last_ain = vic_ain_z;
            if (vic_cs_z !== vic_we_z) cs_we_diff++;
            prev_cs = vic_cs_z;
        end
        check("z_no_ram_we", 32'(we_seen), 0);
        check("z_writes", 32'(writes), 64);
        check("z_last_ain", last_ain, 32'h3f);
        check("z_cs_eq_we", 32'(cs_we_diff), 0);
        check("z_tab_addr", tab_addr_z, 32'h3f);
        check("z_cs_end", vic_cs_z, 0);
`ifdef VIC_IRQ_ACK_EN
        check("z_busy_end", busy_z, 1);
        check("z_done_end", done_z, 0);
`else
        check("z_done_end", done_z, 1);
        check("z_busy_end", busy_z, 0);
`endif
        extra = 0;
        repeat (20) begin
            tick();
            if (vic_cs_z) extra++;
        end
        check("z_no_wrap", 32'(extra), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
